alu_ctrl: RTL and testbench

- Sequential initiator/front-end for the 4-bit combinational ALU.
- Accepts operation requests over a valid/ready handshake and drives the ALU's operand and opcode inputs from registers.
- Waits a configurable settle time, captures result and flags, and presents them on a valid/ready response channel.
- Sits between the decode/control logic and the ALU instance.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_ctrl_rsp_reg.sv | 41 ++++
 rtl/alu_ctrl.sv | 148 ++++++++++++++
 tb/tb_alu_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings, FSM state type and datapath width for the ALU front-end
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_ctrl_rsp_reg.sv
// rtl/alu_ctrl_rsp_reg.sv - result/flag capture register with valid/ready hold, reusable behind any multi-cycle unit
module alu_ctrl_rsp_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic [WIDTH-1:0] cap_result,
  input  logic             cap_overflow,
  input  logic             cap_cf,
  input  logic             rsp_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_cf,
  output logic             rsp_zero
);

  // Data only moves on capture, so it holds for as long as the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_cf       <= 1'b0;
      rsp_zero     <= 1'b0;
    end else begin
      if (cap) begin
        rsp_result   <= cap_result;
        rsp_overflow <= cap_overflow;
        rsp_cf       <= cap_cf;
        rsp_zero     <= (cap_result == '0);
      end
      if (cap)
        rsp_valid <= 1'b1;
      else if (rsp_ready)
        rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - registered request/response front-end for the 4-bit combinational ALU
// Optional accumulator chaining (req_acc port) is built when ALU_CTRL_ACC_EN is defined.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_W,
  parameter int ALU_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
`ifdef ALU_CTRL_ACC_EN
  input  logic             req_acc,
`endif
  output logic [WIDTH-1:0] alu_num1,
  output logic [WIDTH-1:0] alu_num2,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic             alu_cf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_cf,
  output logic             rsp_zero,
  output logic             busy
);

  localparam logic [3:0] LAT4 = 4'(ALU_LAT);

  state_t           state, state_nxt;
  logic [3:0]       cnt;
  logic             latch;
  logic             cap;
  logic [WIDTH-1:0] opa;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // RESP accepts a new request on the same edge as the response handshake.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    latch     = 1'b0;
    cap       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          latch     = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (ALU_LAT == 0) begin
          cap       = 1'b1;
          state_nxt = RESP;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          cap       = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        req_ready = rsp_ready;
        if (rsp_ready) begin
          if (req_valid) begin
            latch     = 1'b1;
            state_nxt = DRIVE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= 4'd0;
    else if (state == DRIVE)
      cnt <= LAT4;
    else if (state == WAIT)
      cnt <= cnt - 4'd1;
  end

`ifdef ALU_CTRL_ACC_EN
  logic [WIDTH-1:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (cap)
      acc <= alu_result;
  end

  assign opa = req_acc ? acc : req_a;
`else
  assign opa = req_a;
`endif

  // ALU inputs come only from these registers and hold until the next accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_num1 <= '0;
      alu_num2 <= '0;
      alu_op   <= 3'd0;
    end else if (latch) begin
      alu_num1 <= opa;
      alu_num2 <= req_b;
      alu_op   <= req_op;
    end
  end

  assign busy = (state != IDLE);

  alu_ctrl_rsp_reg #(
    .WIDTH (WIDTH)
  ) u_rsp_reg (
    .clk          (clk),
    .rst          (rst),
    .cap          (cap),
    .cap_result   (alu_result),
    .cap_overflow (alu_overflow),
    .cap_cf       (alu_cf),
    .rsp_ready    (rsp_ready),
    .rsp_valid    (rsp_valid),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_cf       (rsp_cf),
    .rsp_zero     (rsp_zero)
  );

endmodule

// File: tb/tb_alu_ctrl.sv
// tb/tb_alu_ctrl.sv - directed bench for alu_ctrl at ALU_LAT=0 and ALU_LAT=3
// Accumulator chaining vectors run when ALU_CTRL_ACC_EN is defined.
module tb_alu_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req_op;
  logic [3:0] req_a, req_b;
`ifdef ALU_CTRL_ACC_EN
  logic       req_acc;
`endif

  logic       req_valid0, req_ready0, rsp_valid0, rsp_ready0, ov0, cf0, ro0, rc0, rz0, busy0;
  logic [3:0] n1_0, n2_0, res0, rr0;
  logic [2:0] op_0;
  logic       req_valid3, req_ready3, rsp_valid3, rsp_ready3, ov3, cf3, ro3, rc3, rz3, busy3;
  logic [3:0] n1_3, n2_3, res3, rr3;
  logic [2:0] op_3;

  int n_vec = 0;
  int n_err = 0;
  int seen;

  always #5 clk = ~clk;

  function automatic logic [5:0] alu_model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic       c, v;
    s = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[3:0];
        c = s[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      OP_SUB, OP_CMP: begin
        s = {1'b0, a} + {1'b0, ~b} + 5'd1;
        r = s[3:0];
        c = s[4];
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      OP_NOT:  r = ~a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = {3'b000, a == b};
    endcase
    return {v, c, r};
  endfunction

  assign {ov0, cf0, res0} = alu_model(op_0, n1_0, n2_0);
  assign {ov3, cf3, res3} = alu_model(op_3, n1_3, n2_3);

  alu_ctrl #(.WIDTH(4), .ALU_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
`ifdef ALU_CTRL_ACC_EN
    .req_acc(req_acc),
`endif
    .alu_num1(n1_0), .alu_num2(n2_0), .alu_op(op_0),
    .alu_result(res0), .alu_overflow(ov0), .alu_cf(cf0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_result(rr0),
    .rsp_overflow(ro0), .rsp_cf(rc0), .rsp_zero(rz0), .busy(busy0)
  );

  alu_ctrl #(.WIDTH(4), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
`ifdef ALU_CTRL_ACC_EN
    .req_acc(req_acc),
`endif
    .alu_num1(n1_3), .alu_num2(n2_3), .alu_op(op_3),
    .alu_result(res3), .alu_overflow(ov3), .alu_cf(cf3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rr3),
    .rsp_overflow(ro3), .rsp_cf(rc3), .rsp_zero(rz3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    req_op = op;
    req_a  = a;
    req_b  = b;
  endtask

  initial begin
    rst = 1'b1;
    req_valid0 = 1'b0; rsp_ready0 = 1'b0;
    req_valid3 = 1'b0; rsp_ready3 = 1'b0;
    set_req(OP_ADD, 4'd0, 4'd0);
`ifdef ALU_CTRL_ACC_EN
    req_acc = 1'b0;
`endif
    @(negedge clk);
    chk("rst_req_ready", 8'(req_ready0), 8'd1);
    chk("rst_rsp_valid", 8'(rsp_valid0), 8'd0);
    chk("rst_busy", 8'(busy0), 8'd0);
    chk("rst_num1", 8'(n1_0), 8'd0);
    chk("rst_result", 8'(rr0), 8'd0);
    rst = 1'b0;

    // ADD 7+1, zero settle time
    set_req(OP_ADD, 4'd7, 4'd1);
    req_valid0 = 1'b1;
    step();
    req_valid0 = 1'b0;
    chk("add_drive_busy", 8'(busy0), 8'd1);
    chk("add_drive_valid", 8'(rsp_valid0), 8'd0);
    chk("add_drive_ready", 8'(req_ready0), 8'd0);
    chk("add_num", {n1_0, n2_0}, 8'h71);
    chk("add_op", 8'(op_0), 8'(OP_ADD));
    step();
    chk("add_valid", 8'(rsp_valid0), 8'd1);
    chk("add_flags", {rr0, ro0, rc0, rz0, 1'b0}, {4'd8, 1'b1, 1'b0, 1'b0, 1'b0});

    // Backpressure while the next request (SUB 3-3) is held
    set_req(OP_SUB, 4'd3, 4'd3);
    req_valid0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 8'(rsp_valid0), 8'd1);
      chk("bp_result", {rr0, ro0, rc0, rz0, 1'b0}, {4'd8, 1'b1, 1'b0, 1'b0, 1'b0});
      chk("bp_alu", {1'b0, op_0, n1_0}, {1'b0, OP_ADD, 4'd7});
      chk("bp_req_ready", 8'(req_ready0), 8'd0);
    end
    rsp_ready0 = 1'b1;
    #1;
    chk("bp_release_ready", 8'(req_ready0), 8'd1);
    step();
    rsp_ready0 = 1'b0;
    req_valid0 = 1'b0;
    chk("sub_latched_valid", 8'(rsp_valid0), 8'd0);
    chk("sub_latched_alu", {1'b0, op_0, n1_0}, {1'b0, OP_SUB, 4'd3});
    step();
    chk("sub_valid", 8'(rsp_valid0), 8'd1);
    chk("sub_flags", {rr0, ro0, rc0, rz0, 1'b0}, {4'd0, 1'b0, 1'b1, 1'b1, 1'b0});

    // Back-to-back ADD 1+1 then 2+2
    rsp_ready0 = 1'b1;
    req_valid0 = 1'b1;
    set_req(OP_ADD, 4'd1, 4'd1);
    step();
    chk("b2b_gap1", 8'(rsp_valid0), 8'd0);
    chk("b2b_num1", 8'(n1_0), 8'd1);
    set_req(OP_ADD, 4'd2, 4'd2);
    step();
    chk("b2b_valid1", 8'(rsp_valid0), 8'd1);
    chk("b2b_result1", 8'(rr0), 8'd2);
    step();
    req_valid0 = 1'b0;
    chk("b2b_gap2", 8'(rsp_valid0), 8'd0);
    step();
    chk("b2b_valid2", 8'(rsp_valid0), 8'd1);
    chk("b2b_result2", 8'(rr0), 8'd4);
    step();
    chk("b2b_idle_valid", 8'(rsp_valid0), 8'd0);
    chk("b2b_idle_busy", 8'(busy0), 8'd0);
    rsp_ready0 = 1'b0;

    // Three settle cycles: ADD 5+2
    set_req(OP_ADD, 4'd5, 4'd2);
    req_valid3 = 1'b1;
    step();
    req_valid3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lat3_busy", 8'(busy3), 8'd1);
      chk("lat3_valid", 8'(rsp_valid3), 8'd0);
      chk("lat3_req_ready", 8'(req_ready3), 8'd0);
      chk("lat3_alu", {n1_3, n2_3}, 8'h52);
    end
    step();
    chk("lat3_rsp_valid", 8'(rsp_valid3), 8'd1);
    chk("lat3_result", {rr3, ro3, rc3, rz3, 1'b0}, {4'd7, 1'b0, 1'b0, 1'b0, 1'b0});
    rsp_ready3 = 1'b1;
    step();
    rsp_ready3 = 1'b0;
    chk("lat3_done", 8'(rsp_valid3), 8'd0);

    // Reset while in WAIT
    set_req(OP_ADD, 4'd1, 4'd2);
    req_valid3 = 1'b1;
    step();
    req_valid3 = 1'b0;
    step();
    step();
    chk("mid_wait_busy", 8'(busy3), 8'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 8'(rsp_valid3), 8'd0);
    chk("rst_async_busy", 8'(busy3), 8'd0);
    chk("rst_async_ready", 8'(req_ready3), 8'd1);
    step();
    rst = 1'b0;
    rsp_ready3 = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rsp_valid3) seen++;
    end
    rsp_ready3 = 1'b0;
    chk("rst_no_response", 8'(seen), 8'd0);
    chk("rst_after_busy", 8'(busy3), 8'd0);

`ifdef ALU_CTRL_ACC_EN
    // Chain: ADD 2+3, then acc + 4
    rsp_ready0 = 1'b1;
    req_valid0 = 1'b1;
    req_acc = 1'b0;
    set_req(OP_ADD, 4'd2, 4'd3);
    step();
    req_acc = 1'b1;
    set_req(OP_ADD, 4'd9, 4'd4);
    step();
    chk("acc_first", 8'(rr0), 8'd5);
    step();
    req_valid0 = 1'b0;
    chk("acc_num1", 8'(n1_0), 8'd5);
    step();
    chk("acc_second_valid", 8'(rsp_valid0), 8'd1);
    chk("acc_second", 8'(rr0), 8'd9);
    step();
    req_acc = 1'b0;
    rsp_ready0 = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
